// File: rtl/ra_pkg.sv
// Constants and field-layout helpers shared by both ends of the remote-access protocol.
package ra_pkg;
  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_TAIL = 2'b01;
  localparam logic [1:0] FT_HEAD = 2'b10;
  localparam logic [1:0] FT_ALL  = 2'b11;

  localparam logic [1:0] SF_I_REQ  = 2'd0;
  localparam logic [1:0] SF_D_REQ  = 2'd1;
  localparam logic [1:0] SF_I_RESP = 2'd2;
  localparam logic [1:0] SF_D_RESP = 2'd3;

  function automatic int flow_bits(input int extra);
    return extra;
  endfunction

  function automatic int flit_width(input int id_bits, input int extra, input int type_bits,
                                    input int vc_bits, input int data_width);
    return 2 * id_bits + flow_bits(extra) + type_bits + vc_bits + data_width;
  endfunction

  // Field LSB offsets, payload at bit 0 and source at the top.
  function automatic int vc_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int type_lsb(input int vc_bits, input int data_width);
    return vc_lsb(data_width) + vc_bits;
  endfunction

  function automatic int flow_lsb(input int type_bits, input int vc_bits, input int data_width);
    return type_lsb(vc_bits, data_width) + type_bits;
  endfunction

  function automatic int dest_lsb(input int extra, input int type_bits, input int vc_bits,
                                  input int data_width);
    return flow_lsb(type_bits, vc_bits, data_width) + flow_bits(extra);
  endfunction

  function automatic int src_lsb(input int id_bits, input int extra, input int type_bits,
                                 input int vc_bits, input int data_width);
    return dest_lsb(extra, type_bits, vc_bits, data_width) + id_bits;
  endfunction
endpackage

// File: rtl/ra_flit_unpack.sv
// Combinational split of a remote-access flit into its fields.
module ra_flit_unpack
  import ra_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int VC_BITS    = 1,
  parameter int ID_BITS    = 4,
  parameter int EXTRA      = 2,
  parameter int TYPE_BITS  = 2,
  parameter int FLIT_WIDTH = flit_width(ID_BITS, EXTRA, TYPE_BITS, VC_BITS, DATA_WIDTH)
) (
  input  logic [FLIT_WIDTH-1:0] flit,
  output logic [ID_BITS-1:0]    source,
  output logic [ID_BITS-1:0]    dest,
  output logic [EXTRA-1:0]      sub_flow,
  output logic [TYPE_BITS-1:0]  flit_type,
  output logic [VC_BITS-1:0]    vc,
  output logic [DATA_WIDTH-1:0] payload
);
  localparam int VC_LSB   = vc_lsb(DATA_WIDTH);
  localparam int TYPE_LSB = type_lsb(VC_BITS, DATA_WIDTH);
  localparam int FLOW_LSB = flow_lsb(TYPE_BITS, VC_BITS, DATA_WIDTH);
  localparam int DEST_LSB = dest_lsb(EXTRA, TYPE_BITS, VC_BITS, DATA_WIDTH);
  localparam int SRC_LSB  = src_lsb(ID_BITS, EXTRA, TYPE_BITS, VC_BITS, DATA_WIDTH);

  assign payload   = flit[DATA_WIDTH-1:0];
  assign vc        = flit[VC_LSB +: VC_BITS];
  assign flit_type = flit[TYPE_LSB +: TYPE_BITS];
  assign sub_flow  = flit[FLOW_LSB +: EXTRA];
  assign dest      = flit[DEST_LSB +: ID_BITS];
  assign source    = flit[SRC_LSB +: ID_BITS];
endmodule

// File: rtl/ra_packetizer_mem.sv
// Memory-side responder: decodes request flits, runs one memory access, returns the response.
module ra_packetizer_mem
  import ra_pkg::*;
#(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int REAL_ADDR_BITS = 16,
  parameter int VC_BITS        = 1,
  parameter int ID_BITS        = 4,
  parameter int EXTRA          = 2,
  parameter int TYPE_BITS      = 2,
  parameter int FLIT_WIDTH     = flit_width(ID_BITS, EXTRA, TYPE_BITS, VC_BITS, DATA_WIDTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [FLIT_WIDTH-1:0]   flit_received,
  input  logic                    v_rec_flit,
  output logic                    accept,
  output logic [FLIT_WIDTH-1:0]   flit_to_send,
  output logic                    v_send_flit,
  input  logic                    ready,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_valid,
  output logic                    err_stray
);
  typedef enum logic [2:0] {
    IDLE, WAIT_TAIL, MEM_RD, MEM_WAIT, MEM_WR, SEND_HEAD, SEND_TAIL, SEND_ACK
  } state_t;

  state_t                state;
  logic                  running;
  logic [ID_BITS-1:0]    req_src;
  logic [EXTRA-1:0]      req_flow;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [ID_BITS-1:0]    rx_src;
  logic [ID_BITS-1:0]    rx_dest;
  logic [EXTRA-1:0]      rx_flow;
  logic [TYPE_BITS-1:0]  rx_type;
  logic [VC_BITS-1:0]    rx_vc;
  logic [DATA_WIDTH-1:0] rx_payload;

  ra_flit_unpack #(
    .DATA_WIDTH(DATA_WIDTH), .VC_BITS(VC_BITS), .ID_BITS(ID_BITS),
    .EXTRA(EXTRA), .TYPE_BITS(TYPE_BITS), .FLIT_WIDTH(FLIT_WIDTH)
  ) u_unpack (
    .flit(flit_received), .source(rx_src), .dest(rx_dest), .sub_flow(rx_flow),
    .flit_type(rx_type), .vc(rx_vc), .payload(rx_payload)
  );

  // Requests are addressed to this node by routing, so dest and vc carry nothing here.
  logic unused_fields;
  assign unused_fields = ^{rx_dest, rx_vc};

  logic take, is_req, is_all, is_head, tail_match, rd_done;
  assign take       = accept & v_rec_flit;
  assign is_req     = (rx_flow == EXTRA'(SF_I_REQ)) || (rx_flow == EXTRA'(SF_D_REQ));
  assign is_all     = rx_type == TYPE_BITS'(FT_ALL);
  assign is_head    = rx_type == TYPE_BITS'(FT_HEAD);
  assign tail_match = (rx_type == TYPE_BITS'(FT_TAIL)) && (rx_src == req_src) && (rx_flow == req_flow);
  assign rd_done    = ((state == MEM_RD) && mem_ready && mem_valid) || ((state == MEM_WAIT) && mem_valid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      running   <= 1'b0;
      err_stray <= 1'b0;
    end else begin
      running   <= 1'b1;
      err_stray <= 1'b0;
      case (state)
        IDLE: if (take && is_req) begin
          if (is_all)       state <= MEM_RD;
          else if (is_head) state <= WAIT_TAIL;
          else              err_stray <= 1'b1;
        end
        WAIT_TAIL: if (take) begin
          if (tail_match) state <= MEM_WR;
          else            err_stray <= 1'b1;
        end
        MEM_RD:    if (mem_ready) state <= mem_valid ? SEND_HEAD : MEM_WAIT;
        MEM_WAIT:  if (mem_valid) state <= SEND_HEAD;
        MEM_WR:    if (mem_ready) state <= SEND_ACK;
        SEND_HEAD: if (ready) state <= SEND_TAIL;
        SEND_TAIL: if (ready) state <= IDLE;
        SEND_ACK:  if (ready) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Request fields and data only matter while the state says so; they need no reset.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && take && is_req && (is_all || is_head)) begin
      req_src  <= rx_src;
      req_flow <= rx_flow;
      req_addr <= rx_payload;
    end
    if ((state == WAIT_TAIL) && take && tail_match) wr_data <= rx_payload;
    if (rd_done) rd_data <= mem_rdata;
  end

  assign accept      = running && ((state == IDLE) || (state == WAIT_TAIL));
  assign mem_read    = state == MEM_RD;
  assign mem_write   = state == MEM_WR;
  assign mem_addr    = (mem_read || mem_write) ? ADDRESS_BITS'(req_addr[REAL_ADDR_BITS-1:0]) : '0;
  assign mem_wdata   = mem_write ? wr_data : '0;
  assign v_send_flit = (state == SEND_HEAD) || (state == SEND_TAIL) || (state == SEND_ACK);

  logic [TYPE_BITS-1:0]  resp_type;
  logic [DATA_WIDTH-1:0] resp_payload;

  always_comb begin
    resp_type    = TYPE_BITS'(FT_ALL);
    resp_payload = req_addr;
    if (state == SEND_HEAD) resp_type = TYPE_BITS'(FT_HEAD);
    if (state == SEND_TAIL) begin
      resp_type    = TYPE_BITS'(FT_TAIL);
      resp_payload = rd_data;
    end
    flit_to_send = '0;
    if (v_send_flit)
      flit_to_send = {ID_BITS'(CORE), req_src, req_flow + EXTRA'(SF_I_RESP), resp_type,
                      {VC_BITS{1'b0}}, resp_payload};
  end
endmodule

// File: tb/tb_ra_packetizer_mem.sv
// Scoreboard bench for ra_packetizer_mem: directed scenarios followed by random request traffic.
`timescale 1ns/1ps
module tb_ra_packetizer_mem;
  localparam int CORE = 1;
  localparam int FW   = 45;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [FW-1:0] flit_received = '0;
  logic          v_rec_flit = 1'b0;
  logic          accept;
  logic [FW-1:0] flit_to_send;
  logic          v_send_flit;
  logic          ready = 1'b0;
  logic          mem_read, mem_write;
  logic [31:0]   mem_addr, mem_wdata;
  logic          mem_ready = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          mem_valid = 1'b0;
  logic          err_stray;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ra_packetizer_mem #(.CORE(CORE)) dut (
    .clock(clock), .reset(reset), .flit_received(flit_received), .v_rec_flit(v_rec_flit),
    .accept(accept), .flit_to_send(flit_to_send), .v_send_flit(v_send_flit), .ready(ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .err_stray(err_stray)
  );

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } mem_op_t;

  logic [FW-1:0] exp_flits[$];
  mem_op_t       exp_mem[$];
  int            exp_err = 0;
  int            got_err = 0;
  logic [31:0]   ref_mem[int];
  logic [31:0]   store[int];

  bit          have_head = 0;
  int          head_src, head_sf;
  logic [31:0] head_addr;

  int          force_delay = -1;
  int          block_left = 0;
  bit          pend = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int src, input int dst, input int sf, input int ty,
                                       input logic [31:0] p);
    return {4'(src), 4'(dst), 2'(sf), 2'(ty), 1'b0, p};
  endfunction

  function automatic logic [31:0] init_val(input int a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] store_rd(input int a);
    return store.exists(a) ? store[a] : init_val(a);
  endfunction

  // Reference behaviour: what each accepted request flit must eventually produce.
  task automatic model(input logic [FW-1:0] f);
    int          src = int'(f[44:41]);
    int          sf  = int'(f[36:35]);
    int          ty  = int'(f[34:33]);
    logic [31:0] p   = f[31:0];
    int          loc;
    if (have_head) begin
      if (ty == 1 && src == head_src && sf == head_sf) begin
        have_head = 0;
        loc = int'(head_addr & 32'hFFFF);
        exp_mem.push_back('{wr: 1'b1, addr: 32'(loc), data: p});
        ref_mem[loc] = p;
        exp_flits.push_back(mk(CORE, src, sf + 2, 3, head_addr));
      end else exp_err++;
    end else if (sf < 2) begin
      if (ty == 3) begin
        loc = int'(p & 32'hFFFF);
        exp_mem.push_back('{wr: 1'b0, addr: 32'(loc), data: 32'h0});
        exp_flits.push_back(mk(CORE, src, sf + 2, 2, p));
        exp_flits.push_back(mk(CORE, src, sf + 2, 1, ref_rd(loc)));
      end else if (ty == 2) begin
        have_head = 1;
        head_src  = src;
        head_sf   = sf;
        head_addr = p;
      end else exp_err++;
    end
  endtask

  task automatic drive(input logic [FW-1:0] f);
    int n = 0;
    flit_received = f;
    v_rec_flit    = 1'b1;
    while (!accept && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    if (!accept) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=0 expected=1");
      v_rec_flit = 1'b0;
      return;
    end
    model(f);
    @(posedge clock); #1;
    v_rec_flit = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_flits.size() != 0 || exp_mem.size() != 0) && n < 1000) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_pending", 64'(exp_flits.size() + exp_mem.size()), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    check("err_stray_count", 64'(got_err), 64'(exp_err));
  endtask

  // Network sink: random backpressure, or a forced stall of block_left send cycles.
  initial forever begin
    @(posedge clock); #1;
    if (block_left > 0 && v_send_flit) begin
      ready = 1'b0;
      block_left--;
    end else ready = ($urandom_range(0, 3) != 0);
  end

  // Memory bank: random accept, read data after 0..3 cycles (or force_delay).
  initial begin
    int d;
    int pend_delay;
    logic [31:0] pend_data;
    forever begin
      @(posedge clock); #1;
      mem_ready = 1'b0;
      mem_valid = 1'b0;
      if (pend) begin
        if (pend_delay == 0) begin
          mem_valid = 1'b1;
          mem_rdata = pend_data;
          pend      = 0;
        end else pend_delay--;
      end else if ((mem_read || mem_write) && $urandom_range(0, 2) != 0) begin
        mem_ready = 1'b1;
        if (mem_write) store[int'(mem_addr)] = mem_wdata;
        else begin
          d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
          pend_data = store_rd(int'(mem_addr));
          if (d == 0) begin
            mem_valid = 1'b1;
            mem_rdata = pend_data;
          end else begin
            pend       = 1;
            pend_delay = d - 1;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a flit or memory handshake.
  initial begin
    logic [FW-1:0] prev_flit;
    logic [FW-1:0] e;
    bit            prev_stall;
    mem_op_t       op;
    prev_stall = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_stall = 0;
        continue;
      end
      if (err_stray) got_err++;
      if (prev_stall) check("flit_hold", {19'd0, v_send_flit, flit_to_send}, {19'd0, 1'b1, prev_flit});
      if (v_send_flit) check("accept_while_sending", 64'(accept), 64'd0);
      if (v_send_flit && ready) begin
        if (exp_flits.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_flit got=%h expected=none", flit_to_send);
        end else begin
          e = exp_flits.pop_front();
          check("resp_flit", 64'(flit_to_send), 64'(e));
        end
      end
      prev_stall = v_send_flit && !ready;
      prev_flit  = flit_to_send;
      if (mem_read && mem_write) begin
        checks++;
        failures++;
        $display("FAIL both_strobes got=11 expected=one");
      end
      if ((mem_read || mem_write) && mem_ready) begin
        if (exp_mem.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_op got=rd%0d_wr%0d addr=%h expected=none", mem_read, mem_write, mem_addr);
        end else begin
          op = exp_mem.pop_front();
          check("mem_op_is_write", 64'(mem_write), 64'(op.wr));
          check("mem_addr", 64'(mem_addr), 64'(op.addr));
          if (op.wr) check("mem_wdata", 64'(mem_wdata), 64'(op.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int src, sf, ty;
    logic [31:0] p;

    repeat (3) @(posedge clock);
    #1;
    check("rst_ctl", 64'({accept, v_send_flit, mem_read, mem_write, err_stray}), 64'd0);
    check("rst_flit", 64'(flit_to_send), 64'd0);
    check("rst_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("accept_idle", 64'(accept), 64'd1);

    // Read with a three-cycle memory latency.
    ref_mem[32'h40] = 32'hDEADBEEF;
    store[32'h40]   = 32'hDEADBEEF;
    force_delay     = 3;
    drive(mk(2, 1, 1, 3, 32'h0001_0040));
    drain();
    force_delay = -1;

    // Write via HEAD + TAIL.
    drive(mk(5, 1, 0, 2, 32'h0001_0010));
    drive(mk(5, 1, 0, 1, 32'h1234_5678));
    drain();

    // Read-back of the write while the network stalls the HEAD for five cycles.
    block_left = 5;
    drive(mk(6, 1, 0, 3, 32'h0002_0010));
    drain();

    // Stray TAIL, then a foreign HEAD in the middle of a write.
    drive(mk(3, 1, 1, 1, 32'h0000_0099));
    drive(mk(5, 1, 1, 2, 32'h0001_0020));
    drive(mk(7, 1, 1, 2, 32'h0001_0030));
    drive(mk(5, 1, 1, 1, 32'hCAFE_F00D));
    drain();

    // Response-class flit is swallowed silently.
    drive(mk(4, 1, 2, 2, 32'h0001_0050));
    drain();

    // Reset while waiting on read data; the late stale data must be ignored afterwards.
    force_delay = 12;
    drive(mk(2, 1, 0, 3, 32'h0001_0080));
    n = 0;
    while (!pend && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("reached_mem_wait", 64'(pend), 64'd1);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("midrst_ctl", 64'({accept, v_send_flit, mem_read, mem_write, err_stray}), 64'd0);
    check("midrst_flit", 64'(flit_to_send), 64'd0);
    check("midrst_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    exp_flits.delete();
    exp_mem.delete();
    have_head = 0;
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    force_delay = -1;
    ref_mem[32'hC4] = 32'h0BAD_F00D;
    store[32'hC4]   = 32'h0BAD_F00D;
    drive(mk(9, 1, 1, 3, 32'h0001_00C4));
    drain();

    // Random traffic, biased toward completing writes.
    for (int i = 0; i < 80; i++) begin
      if (have_head && $urandom_range(0, 3) != 0) begin
        src = head_src;
        sf  = head_sf;
        ty  = 1;
      end else begin
        src = int'($urandom_range(0, 15));
        sf  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 3));
        ty  = ($urandom_range(0, 4) < 3) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 3));
      end
      p = {16'($urandom), 10'd0, 6'($urandom_range(0, 63))};
      if (ty == 1 && have_head) p = $urandom;
      drive(mk(src, CORE, sf, ty, p));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clock);
        #1;
      end
    end
    if (have_head) drive(mk(head_src, CORE, head_sf, 1, 32'h7777_0001));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ra_packetizer_mem.md
# ra_packetizer_mem

Memory-side responder for the remote-access cache protocol. It takes request flits from the network, decodes them, and performs the access on the local memory port. Requests are either instruction or data, and either read or write. It then returns the matching response packet to the requesting core. It sits between the router's local port and the node's memory bank, and forms the far end of the core-side remote-access packetizer.

## Interface
- `CORE`, default 0: this node's ID; placed in the source field of responses.
- `DATA_WIDTH`, default 32: flit payload and memory data width.
- `ADDRESS_BITS`, default 32: global address width.
- `REAL_ADDR_BITS`, default 16: local address width; the upper address bits are the node ID.
- `VC_BITS`, default 1; `ID_BITS`, default 4; `EXTRA`, default 2; `TYPE_BITS`, default 2.
- Flit layout, MSB first: {source[ID_BITS], dest[ID_BITS], sub_flow[EXTRA], type[TYPE_BITS], vc[VC_BITS], payload[DATA_WIDTH]}.
- `clock`  input  1  single clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `flit_received`  input  FLIT_WIDTH  request flit from the network.
- `v_rec_flit`  input  1  `flit_received` is valid.
- `accept`  output  1  the block consumes `flit_received` this cycle.
- `flit_to_send`  output  FLIT_WIDTH  response flit.
- `v_send_flit`  output  1  `flit_to_send` is valid.
- `ready`  input  1  the network takes `flit_to_send` this cycle.
- `mem_read`, `mem_write`  output  1  memory strobes.
- `mem_addr`  output  ADDRESS_BITS  local address.
- `mem_wdata`  output  DATA_WIDTH  write data.
- `mem_ready`  input  1  memory accepts the strobe this cycle.
- `mem_rdata`  input  DATA_WIDTH  read data.
- `mem_valid`  input  1  `mem_rdata` is valid.
- `err_stray`  output  1  one-cycle pulse when a flit is dropped.

## Operation
**Codes**
- Flit types: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, ALL=2'b11.
- Request sub_flow: 0 = instruction, 1 = data.
- Response sub_flow = request sub_flow + 2.

**Response flit fields**
- source = CORE.
- dest = the request's source.
- vc = 0.

**Address mapping**
- `mem_addr` = request payload[REAL_ADDR_BITS-1:0], zero-extended to ADDRESS_BITS.
- The stored address is the full payload; it is echoed unchanged in responses.

**State machine: IDLE, WAIT_TAIL, MEM_RD, MEM_WAIT, MEM_WR, SEND_HEAD, SEND_TAIL, SEND_ACK**
- **IDLE** (`accept`=1). A flit transfers when `v_rec_flit` is high.
  - sub_flow 0/1, type ALL: latch source, sub_flow and address; go to MEM_RD.
  - sub_flow 0/1, type HEAD: latch the same fields; go to WAIT_TAIL.
  - sub_flow 0/1, type TAIL or BODY: drop the flit and pulse `err_stray`.
  - sub_flow 2/3: drop silently, with no error.
- **WAIT_TAIL** (`accept`=1).
  - A TAIL with matching source and sub_flow: latch the payload as write data; go to MEM_WR.
  - Any other valid flit: drop it, pulse `err_stray`, stay in WAIT_TAIL.
- **MEM_RD**: `mem_read`=1 and `mem_addr` are held until an edge where `mem_ready`=1; then go to MEM_WAIT.
- **MEM_WAIT**: on `mem_valid`=1, latch `mem_rdata`; go to SEND_HEAD. `mem_valid` is permitted in the same cycle as `mem_ready`.
- **MEM_WR**: `mem_write`=1 with `mem_addr` and `mem_wdata` held until `mem_ready`=1; then go to SEND_ACK.
- **SEND_HEAD**: sends a HEAD flit carrying the address. On `ready`, go to SEND_TAIL.
- **SEND_TAIL**: sends a TAIL flit carrying the read data. On `ready`, go to IDLE.
- **SEND_ACK**: sends an ALL flit carrying the address. On `ready`, go to IDLE.
- Only one request is outstanding at a time. `accept`=0 in every state except IDLE and WAIT_TAIL.

## Timing
- **Reset:** while `reset`=0, all outputs are 0 (including `accept`) and the state is IDLE. Assertion mid-operation abandons the request immediately. No partial response is emitted and memory strobes drop asynchronously.
- **Output timing:** every output is a register or a pure decode of state, with no combinational path from inputs.
  - Exception: `accept` is a decode of state only.
- **Flit hold:** `flit_to_send` and `v_send_flit` stay stable until the transfer edge (`v_send_flit` & `ready`). The next flit follows in the very next cycle.
- **Read latency:** request accepted at edge 0 → `mem_read` high from cycle 1.
  - With zero memory wait: `mem_ready`=`mem_valid`=1 in cycle 1, HEAD valid in cycle 2, TAIL valid in cycle 3.
- **Write latency:** TAIL accepted at edge 0 → `mem_write` in cycle 1 → ALL ack valid in cycle 2 at the earliest.
- **`err_stray`:** asserted for exactly the one cycle after the dropping edge.

## Structure
- **Shared `ra_pkg`** (constants common with the core-side packetizer):
  - flit type codes;
  - sub_flow codes: I_REQ=0, D_REQ=1, I_RESP=2, D_RESP=3;
  - FLOW_BITS and FLIT_WIDTH formulas;
  - field offset functions.
- **Sub-module `ra_flit_unpack`:** combinational field split (source, dest, sub_flow, type, vc, payload). It is reused by the core-side packetizer.

## Test plan
1. **Read:** CORE=1. Flit {src 2, dst 1, sf 1, ALL, payload 0x0001_0040}; memory returns 0xDEADBEEF after 3 cycles.
   - Expect `mem_addr`=0x0040.
   - Expect HEAD {1, 2, sf 3, payload 0x0001_0040}, then TAIL {1, 2, sf 3, payload 0xDEADBEEF}.
2. **Write:** HEAD {src 5, sf 0, payload 0x0001_0010}, then TAIL with data 0x12345678.
   - Expect one `mem_write` cycle with addr 0x0010 and data 0x12345678.
   - Expect an ALL ack {1, 5, sf 2, payload 0x0001_0010}.
3. **Send backpressure:** `ready`=0 for 5 cycles in SEND_HEAD.
   - Expect `flit_to_send` held constant, `accept`=0, exactly two flits sent in total.
4. **Stray and mismatched flits:**
   - A stray TAIL in IDLE gives an `err_stray` pulse and no memory access.
   - A HEAD from src 7 during WAIT_TAIL for src 5 is dropped with `err_stray`; the later src 5 TAIL still completes the write.
5. **Reset mid-read:** `reset` asserted low during MEM_WAIT.
   - Expect all outputs 0 immediately.
   - After release, a new read completes normally and the stale `mem_valid` is ignored.
6. **Response-class flit:** a sf 2 HEAD flit in IDLE is consumed with no `err_stray` and no memory strobe.
